// File: rtl/messbauer_diff_discriminator_decoder_pkg.sv
// Shared types and defaults for the differential-discriminator receive path.
package messbauer_diff_discriminator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOWER_ACTIVE,
    ST_UPPER_ACTIVE,
    ST_STUCK
  } state_t;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_MIN_LOWER_DURATION = 2;
  localparam int DEF_MAX_LOWER_DURATION = 255;
  localparam int DEF_COUNTER_WIDTH      = 16;

  // Duration counter is never narrower than 8 bits.
  function automatic int dur_width(input int max_dur);
    int w;
    w = $clog2(max_dur + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/messbauer_diff_discriminator_decoder_if.sv
// Snapshot hand-off port: per-channel totals with valid/ready flow control.
interface messbauer_diff_discriminator_decoder_if
  import messbauer_diff_discriminator_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) ();

  logic [COUNTER_WIDTH-1:0] accepted_count;
  logic [COUNTER_WIDTH-1:0] rejected_count;
  logic                     count_overflow;
  logic                     result_valid;
  logic                     result_ready;

  modport master (
    output accepted_count,
    output rejected_count,
    output count_overflow,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  accepted_count,
    input  rejected_count,
    input  count_overflow,
    input  result_valid,
    output result_ready
  );

endinterface

// File: rtl/messbauer_diff_discriminator_decoder_sync.sv
// Multi-flop synchronizer with registered level and edge outputs, all aligned.
module messbauer_signal_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic areset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_level <= r_sync[SYNC_STAGES-1];
      r_rise  <= r_sync[SYNC_STAGES-1] & ~r_level;
      r_fall  <= ~r_sync[SYNC_STAGES-1] & r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/messbauer_diff_discriminator_decoder.sv
// Impulse classifier: accepted/rejected counting per velocity channel with
// snapshot hand-off on each channel advance.
module messbauer_diff_discriminator_decoder
  import messbauer_diff_discriminator_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int MIN_LOWER_DURATION = DEF_MIN_LOWER_DURATION,
  parameter int MAX_LOWER_DURATION = DEF_MAX_LOWER_DURATION,
  parameter int COUNTER_WIDTH      = DEF_COUNTER_WIDTH
) (
  input  logic aclk,
  input  logic areset,
  input  logic channel,
  input  logic lower_threshold,
  input  logic upper_threshold,
  messbauer_diff_discriminator_decoder_if.master result,
  output logic event_accepted,
  output logic event_rejected,
  output logic result_overrun,
  output logic stuck_error
);

  localparam int                 DUR_W   = dur_width(MAX_LOWER_DURATION);
  localparam logic [DUR_W-1:0]   MIN_D   = DUR_W'(MIN_LOWER_DURATION);
  localparam logic [DUR_W-1:0]   MAX_D   = DUR_W'(MAX_LOWER_DURATION);
  localparam logic [DUR_W-1:0]   STUCK_D = DUR_W'(MAX_LOWER_DURATION - 1);

  function automatic logic [COUNTER_WIDTH:0] sat_inc(input logic [COUNTER_WIDTH-1:0] cnt,
                                                     input logic inc);
    if (!inc)
      return {1'b0, cnt};
    if (&cnt)
      return {1'b1, cnt};
    return {1'b0, cnt + 1'b1};
  endfunction

  function automatic logic [DUR_W-1:0] dur_inc(input logic [DUR_W-1:0] d);
    return (d >= MAX_D) ? MAX_D : d + 1'b1;
  endfunction

  logic w_low_lvl, w_low_rise, w_low_fall;
  logic w_up_lvl, w_up_rise, w_up_fall;
  logic w_ch_lvl, w_ch_rise, w_ch_fall;
  logic w_unused;

  messbauer_signal_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lower (
    .aclk(aclk), .areset(areset), .i_async(lower_threshold),
    .o_level(w_low_lvl), .o_rise(w_low_rise), .o_fall(w_low_fall)
  );

  messbauer_signal_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_upper (
    .aclk(aclk), .areset(areset), .i_async(upper_threshold),
    .o_level(w_up_lvl), .o_rise(w_up_rise), .o_fall(w_up_fall)
  );

  messbauer_signal_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_channel (
    .aclk(aclk), .areset(areset), .i_async(channel),
    .o_level(w_ch_lvl), .o_rise(w_ch_rise), .o_fall(w_ch_fall)
  );

  assign w_unused = ^{w_low_fall, w_up_rise, w_up_fall, w_ch_lvl, w_ch_fall};

  state_t             r_state;
  logic [DUR_W-1:0]   r_dur;
  logic               r_ev_acc;
  logic               r_ev_rej;
  logic               r_stuck;
  logic               w_accept;
  logic               w_reject;

  // Impulse completion decision; lower fall with upper high counts as rejected.
  always_comb begin
    w_accept = 1'b0;
    w_reject = 1'b0;
    case (r_state)
      ST_LOWER_ACTIVE: begin
        if (!w_low_lvl) begin
          if (w_up_lvl)
            w_reject = 1'b1;
          else if (r_dur >= MIN_D)
            w_accept = 1'b1;
        end
      end
      ST_UPPER_ACTIVE: begin
        if (!w_low_lvl)
          w_reject = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= ST_IDLE;
      r_dur    <= '0;
      r_ev_acc <= 1'b0;
      r_ev_rej <= 1'b0;
      r_stuck  <= 1'b0;
    end else begin
      r_ev_acc <= w_accept;
      r_ev_rej <= w_reject;
      case (r_state)
        ST_IDLE: begin
          if (w_low_rise) begin
            r_dur   <= DUR_W'(1);
            r_state <= ST_LOWER_ACTIVE;
          end
        end
        ST_LOWER_ACTIVE: begin
          if (!w_low_lvl) begin
            r_state <= ST_IDLE;
          end else if (r_dur >= STUCK_D) begin
            r_dur   <= MAX_D;
            r_stuck <= 1'b1;
            r_state <= ST_STUCK;
          end else begin
            r_dur <= dur_inc(r_dur);
            if (w_up_lvl)
              r_state <= ST_UPPER_ACTIVE;
          end
        end
        ST_UPPER_ACTIVE: begin
          if (!w_low_lvl) begin
            r_state <= ST_IDLE;
          end else if (r_dur >= STUCK_D) begin
            r_dur   <= MAX_D;
            r_stuck <= 1'b1;
            r_state <= ST_STUCK;
          end else begin
            r_dur <= dur_inc(r_dur);
          end
        end
        ST_STUCK: begin
          if (!w_low_lvl && !w_up_lvl)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic [COUNTER_WIDTH-1:0] r_acc, r_rej;
  logic                     r_ovf;
  logic [COUNTER_WIDTH-1:0] r_snap_acc, r_snap_rej;
  logic                     r_snap_ovf;
  logic                     r_valid;
  logic                     r_overrun;
  logic [COUNTER_WIDTH:0]   w_acc_nx, w_rej_nx;
  logic                     w_ovf_nx;

  assign w_acc_nx = sat_inc(r_acc, w_accept);
  assign w_rej_nx = sat_inc(r_rej, w_reject);
  assign w_ovf_nx = r_ovf | w_acc_nx[COUNTER_WIDTH] | w_rej_nx[COUNTER_WIDTH];

  // Snapshot includes an impulse finishing on the close cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_acc      <= '0;
      r_rej      <= '0;
      r_ovf      <= 1'b0;
      r_snap_acc <= '0;
      r_snap_rej <= '0;
      r_snap_ovf <= 1'b0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_ch_rise) begin
      r_snap_acc <= w_acc_nx[COUNTER_WIDTH-1:0];
      r_snap_rej <= w_rej_nx[COUNTER_WIDTH-1:0];
      r_snap_ovf <= w_ovf_nx;
      r_valid    <= 1'b1;
      if (r_valid && !result.result_ready)
        r_overrun <= 1'b1;
      r_acc <= '0;
      r_rej <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= w_acc_nx[COUNTER_WIDTH-1:0];
      r_rej <= w_rej_nx[COUNTER_WIDTH-1:0];
      r_ovf <= w_ovf_nx;
      if (r_valid && result.result_ready)
        r_valid <= 1'b0;
    end
  end

  assign result.accepted_count = r_snap_acc;
  assign result.rejected_count = r_snap_rej;
  assign result.count_overflow = r_snap_ovf;
  assign result.result_valid   = r_valid;
  assign event_accepted        = r_ev_acc;
  assign event_rejected        = r_ev_rej;
  assign result_overrun        = r_overrun;
  assign stuck_error           = r_stuck;

endmodule
